alu_result_buffer: RTL and testbench

//  Downstream stage of the 8-bit ALU: captures each ALU result {cout, zero, y} into
//  a small show-ahead FIFO with valid/ready on both sides. It decouples the ALU from
//  a slower consumer (register writeback / bus master) without losing results.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_rb_mem.sv | 25 ++
 rtl/alu_result_buffer.sv | 101 ++++++++++
 tb/tb_alu_result_buffer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, result record and opcode encodings.
package alu_pkg;

   localparam int unsigned ALU_DATA_W = 8;

   typedef struct packed {
      logic                  cout;
      logic                  zero;
      logic [ALU_DATA_W-1:0] y;
   } alu_result_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_OR  = 4'b0011,
      ALU_XOR = 4'b0101,
      ALU_NOT = 4'b0110,
      ALU_INC = 4'b0111
   } alu_op_e;

endpackage

// File: rtl/alu_rb_mem.sv
// Result-buffer storage: one synchronous write port, one asynchronous read port.
module alu_rb_mem
   import alu_pkg::*;
#(
   parameter int unsigned W     = $bits(alu_result_t),
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// Show-ahead valid/ready FIFO for ALU results {cout, zero, y}.
// Optional sticky flag outputs are built when ALU_RB_STICKY_FLAGS_EN is defined.
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = ALU_DATA_W,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_y,
   input  logic                     in_cout,
   input  logic                     in_zero,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_y,
   output logic                     out_cout,
   output logic                     out_zero,
`ifdef ALU_RB_STICKY_FLAGS_EN
   input  logic                     sticky_clr,
   output logic                     sticky_cout,
   output logic                     sticky_zero,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = DATA_W + 2;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;
   logic [EW-1:0] w_rd_entry;

   // in_ready looks only at count, so a full buffer never accepts even on a pop cycle.
   assign in_ready  = (r_count != CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign count     = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   alu_rb_mem #(
      .W     (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata ({in_cout, in_zero, in_y}),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_entry)
   );

   assign out_y    = out_valid ? w_rd_entry[DATA_W-1:0] : '0;
   assign out_zero = out_valid ? w_rd_entry[DATA_W]     : 1'b0;
   assign out_cout = out_valid ? w_rd_entry[DATA_W+1]   : 1'b0;

`ifdef ALU_RB_STICKY_FLAGS_EN
   logic r_sticky_cout;
   logic r_sticky_zero;

   // Per-flag: a setting push overrides a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky_cout <= 1'b0;
         r_sticky_zero <= 1'b0;
      end else begin
         if (w_push && in_cout) r_sticky_cout <= 1'b1;
         else if (sticky_clr)   r_sticky_cout <= 1'b0;
         if (w_push && in_zero) r_sticky_zero <= 1'b1;
         else if (sticky_clr)   r_sticky_zero <= 1'b0;
      end
   end

   assign sticky_cout = r_sticky_cout;
   assign sticky_zero = r_sticky_zero;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed self-checking bench for alu_result_buffer (sticky checks under ALU_RB_STICKY_FLAGS_EN).
module tb_alu_result_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_y;
   logic       in_cout;
   logic       in_zero;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_y;
   logic       out_cout;
   logic       out_zero;
   logic [2:0] count;
`ifdef ALU_RB_STICKY_FLAGS_EN
   logic       sticky_clr;
   logic       sticky_cout;
   logic       sticky_zero;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_result_buffer #(
      .DATA_W (8),
      .DEPTH  (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_y        (in_y),
      .in_cout     (in_cout),
      .in_zero     (in_zero),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_y       (out_y),
      .out_cout    (out_cout),
      .out_zero    (out_zero),
`ifdef ALU_RB_STICKY_FLAGS_EN
      .sticky_clr  (sticky_clr),
      .sticky_cout (sticky_cout),
      .sticky_zero (sticky_zero),
`endif
      .count       (count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_q [$];
      rst_n = 1'b0; in_valid = 1'b0; in_y = '0; in_cout = 1'b0; in_zero = 1'b0;
      out_ready = 1'b0;
`ifdef ALU_RB_STICKY_FLAGS_EN
      sticky_clr = 1'b0;
`endif
      // 1. reset state
      repeat (2) step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_out_y",     32'(out_y),     32'h00);
      rst_n = 1'b1;
      step();

      // 2. fill with consumer stalled
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_y = 8'(i);
         step();
         chk("fill_count", 32'(count), 32'(i));
         chk("fill_head",  32'(out_y), 32'h01);
      end
      chk("full_in_ready", 32'(in_ready), 32'd0);
      in_y = 8'h05;
      step();
      chk("full_ignore_count", 32'(count), 32'd4);
      chk("full_hold_head",    32'(out_y), 32'h01);
      out_ready = 1'b1;
      step();
      chk("full_pop_no_push",  32'(count), 32'd3);
      chk("full_pop_head",     32'(out_y), 32'h02);
      in_valid = 1'b0;

      // 3. drain remaining 02,03,04
      for (int i = 2; i <= 4; i++) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_head",  32'(out_y),     32'(i));
         step();
      end
      chk("empty_valid", 32'(out_valid), 32'd0);
      chk("empty_y",     32'(out_y),     32'h00);
      chk("empty_count", 32'(count),     32'd0);
      out_ready = 1'b0;

      // 4. steady push+pop at count=2 across pointer wrap
      in_valid = 1'b1;
      in_y = 8'h20; step();
      in_y = 8'h21; step();
      chk("pp_pre_count", 32'(count), 32'd2);
      exp_q = '{8'h20, 8'h21};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_y = 8'(8'h10 + i);
         exp_q.push_back(in_y);
         chk("pp_head", 32'(out_y), 32'(exp_q.pop_front()));
         step();
         chk("pp_count", 32'(count), 32'd2);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("pp_tail_head", 32'(out_y), 32'(exp_q.pop_front()));
         step();
      end
      chk("pp_empty", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // 5. asynchronous reset with 3 entries held
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_y = 8'(8'h30 + i);
         step();
      end
      in_valid = 1'b0;
      chk("pre_rst_count", 32'(count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_count", 32'(count),     32'd0);
      chk("async_rst_y",     32'(out_y),     32'h00);
      step();
      rst_n = 1'b1;
      step();
      in_valid = 1'b1; in_y = 8'hAA; in_cout = 1'b1; in_zero = 1'b0;
      step();
      in_valid = 1'b0; in_cout = 1'b0;
      chk("post_rst_head",  32'(out_y),     32'hAA);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_count", 32'(count),     32'd1);
      chk("pass_cout",      32'(out_cout),  32'd1);
      chk("pass_zero",      32'(out_zero),  32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("post_rst_drained", 32'(count), 32'd0);

`ifdef ALU_RB_STICKY_FLAGS_EN
      // 6. sticky flags
      chk("sticky_rst_cout", 32'(sticky_cout), 32'd1);
      in_valid = 1'b1; in_y = 8'h00; in_zero = 1'b1; in_cout = 1'b0; sticky_clr = 1'b1;
      step();
      chk("sticky_zero_set",  32'(sticky_zero), 32'd1);
      chk("sticky_cout_clr",  32'(sticky_cout), 32'd0);
      in_y = 8'h01; in_zero = 1'b0; in_cout = 1'b1; sticky_clr = 1'b1;
      step();
      in_valid = 1'b0; in_cout = 1'b0; sticky_clr = 1'b0;
      chk("sticky_cout_win", 32'(sticky_cout), 32'd1);
      chk("sticky_zero_clr", 32'(sticky_zero), 32'd0);
      chk("sticky_head_zero", 32'(out_zero), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
